// File: rtl/ftile_xcvr_rx_lane_aligner.sv
`default_nettype none
// ============================================================================
// Module  : ftile_xcvr_rx_lane_aligner
// Brief   : Per-lane RX word slicer with sync-marker lock, stripping and error counting.
// Revision: 1.0 - initial release
// ============================================================================
module ftile_xcvr_rx_lane_aligner #(
  parameter int                LANES         = 4,
  parameter int                PAR_W         = 80,
  parameter int                DATA_W        = 64,
  parameter int                VALID_BIT     = 79,
  parameter logic [DATA_W-1:0] SYNC_PATTERN  = 64'hA5A5_5A5A_0F0F_F0F0,
  parameter int                MARKER_PERIOD = 16,
  parameter int                LOCK_CNT      = 4,
  parameter int                UNLOCK_CNT    = 8,
  parameter int                ERR_CNT_W     = 16
) (
  input  logic                       rx_clkout,
  input  logic                       reset_n,
  input  logic [LANES*PAR_W-1:0]     rx_parallel_data,
  input  logic                       err_clear,
  output logic [LANES*DATA_W-1:0]    rx_data,
  output logic [LANES-1:0]           rx_valid,
  output logic [LANES-1:0]           lane_locked,
  output logic                       all_locked,
  output logic [LANES*ERR_CNT_W-1:0] err_count
);

  localparam int POS_W  = (MARKER_PERIOD > 2) ? $clog2(MARKER_PERIOD) : 1;
  localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int BAD_W  = (UNLOCK_CNT > 1) ? $clog2(UNLOCK_CNT + 1) : 1;

  localparam logic [POS_W-1:0]     c_POS_LAST   = POS_W'(MARKER_PERIOD - 1);
  localparam logic [POS_W-1:0]     c_POS_ONE    = POS_W'(1);
  localparam logic [GOOD_W-1:0]    c_GOOD_ONE   = GOOD_W'(1);
  localparam logic [GOOD_W-1:0]    c_GOOD_LOCK  = GOOD_W'(LOCK_CNT);
  localparam logic [BAD_W-1:0]     c_BAD_UNLOCK = BAD_W'(UNLOCK_CNT);
  localparam logic [ERR_CNT_W-1:0] c_ERR_MAX    = '1;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    state_t                r_state, w_state_nxt;
    logic [POS_W-1:0]      r_pos, w_pos_nxt;
    logic [GOOD_W-1:0]     r_good, w_good_nxt;
    logic [BAD_W-1:0]      r_bad, w_bad_nxt;
    logic [ERR_CNT_W-1:0]  r_err, w_err_nxt;
    logic [DATA_W-1:0]     r_data;
    logic                  r_valid;
    logic                  r_locked;
    logic                  w_in_v;
    logic                  w_mk;
    logic                  w_slot0;
    logic                  w_miss;
    logic [DATA_W-1:0]     w_pay;

    assign w_in_v  = rx_parallel_data[l*PAR_W + VALID_BIT];
    assign w_pay   = rx_parallel_data[l*PAR_W +: DATA_W];
    assign w_mk    = w_in_v & (w_pay == SYNC_PATTERN);
    assign w_slot0 = (r_pos == '0);

    always_comb begin
      w_state_nxt = r_state;
      w_pos_nxt   = r_pos;
      w_good_nxt  = r_good;
      w_bad_nxt   = r_bad;
      w_miss      = 1'b0;
      if (w_in_v) begin
        w_pos_nxt = (r_pos == c_POS_LAST) ? '0 : r_pos + 1'b1;
        case (r_state)
          ST_HUNT: begin
            if (w_mk) begin
              // The marker just seen defines slot 0, so the next word is slot 1.
              w_pos_nxt  = c_POS_ONE;
              w_good_nxt = c_GOOD_ONE;
              if (LOCK_CNT == 1) begin
                w_state_nxt = ST_LOCKED;
                w_bad_nxt   = '0;
              end else begin
                w_state_nxt = ST_VERIFY;
              end
            end
          end
          ST_VERIFY: begin
            if (w_slot0) begin
              if (w_mk) begin
                w_good_nxt = r_good + 1'b1;
                if (w_good_nxt == c_GOOD_LOCK) begin
                  w_state_nxt = ST_LOCKED;
                  w_bad_nxt   = '0;
                end
              end else begin
                w_state_nxt = ST_HUNT;
                w_good_nxt  = '0;
              end
            end
          end
          ST_LOCKED: begin
            if (w_slot0) begin
              if (w_mk) begin
                w_bad_nxt = '0;
              end else begin
                w_miss    = 1'b1;
                w_bad_nxt = r_bad + 1'b1;
                if (w_bad_nxt == c_BAD_UNLOCK) begin
                  w_state_nxt = ST_HUNT;
                  w_good_nxt  = '0;
                end
              end
            end
          end
          default: begin
            w_state_nxt = ST_HUNT;
            w_good_nxt  = '0;
          end
        endcase
      end
    end

    always_comb begin
      w_err_nxt = r_err;
      if (err_clear) begin
        w_err_nxt = '0;
      end else if (w_miss && (r_err != c_ERR_MAX)) begin
        w_err_nxt = r_err + 1'b1;
      end
    end

    always_ff @(posedge rx_clkout or negedge reset_n) begin
      if (!reset_n) begin
        r_state  <= ST_HUNT;
        r_pos    <= '0;
        r_good   <= '0;
        r_bad    <= '0;
        r_err    <= '0;
        r_data   <= '0;
        r_valid  <= 1'b0;
        r_locked <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_pos    <= w_pos_nxt;
        r_good   <= w_good_nxt;
        r_bad    <= w_bad_nxt;
        r_err    <= w_err_nxt;
        if (w_in_v) begin
          r_data <= w_pay;
        end
        // Uses the pre-update state: slot 0 is always stripped, marker or not.
        r_valid  <= w_in_v & (r_state == ST_LOCKED) & ~w_slot0;
        r_locked <= (w_state_nxt == ST_LOCKED);
      end
    end

    assign rx_data[l*DATA_W +: DATA_W]       = r_data;
    assign rx_valid[l]                       = r_valid;
    assign lane_locked[l]                    = r_locked;
    assign err_count[l*ERR_CNT_W +: ERR_CNT_W] = r_err;
  end : g_lane

  assign all_locked = &lane_locked;

endmodule
`default_nettype wire

// File: tb/tb_ftile_xcvr_rx_lane_aligner.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for ftile_xcvr_rx_lane_aligner: lock, stripping, gaps, marker errors,
// verify failure, counter saturation (narrow second instance) and asynchronous reset.
module tb_ftile_xcvr_rx_lane_aligner;
  localparam int          LANES  = 4;
  localparam int          PAR_W  = 80;
  localparam int          DATA_W = 64;
  localparam int          ERR_W  = 16;
  localparam int          PERIOD = 16;
  localparam logic [63:0] SYNC   = 64'hA5A5_5A5A_0F0F_F0F0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst_n;
  logic [LANES*PAR_W-1:0]   din;
  logic                     err_clear;
  logic [LANES*DATA_W-1:0]  rx_data;
  logic [LANES-1:0]         rx_valid;
  logic [LANES-1:0]         lane_locked;
  logic                     all_locked;
  logic [LANES*ERR_W-1:0]   err_count;

  logic [PAR_W-1:0]         s_din;
  logic                     s_clr;
  logic [DATA_W-1:0]        s_data;
  logic                     s_valid;
  logic                     s_locked;
  logic                     s_all;
  logic [3:0]               s_err;

  ftile_xcvr_rx_lane_aligner u_dut (
    .rx_clkout        (clk),
    .reset_n          (rst_n),
    .rx_parallel_data (din),
    .err_clear        (err_clear),
    .rx_data          (rx_data),
    .rx_valid         (rx_valid),
    .lane_locked      (lane_locked),
    .all_locked       (all_locked),
    .err_count        (err_count)
  );

  // Narrow instance: period 2, immediate lock, 4-bit counter so saturation is reachable.
  ftile_xcvr_rx_lane_aligner #(
    .LANES(1), .MARKER_PERIOD(2), .LOCK_CNT(1), .UNLOCK_CNT(20), .ERR_CNT_W(4)
  ) u_dut_sat (
    .rx_clkout        (clk),
    .reset_n          (rst_n),
    .rx_parallel_data (s_din),
    .err_clear        (s_clr),
    .rx_data          (s_data),
    .rx_valid         (s_valid),
    .lane_locked      (s_locked),
    .all_locked       (s_all),
    .err_count        (s_err)
  );

  logic [PAR_W-1:0] lw [LANES];
  int               t_pos [LANES];
  int               t_cnt [LANES];
  logic [63:0]      t_last [LANES];
  int               n_checks = 0;
  int               n_fail   = 0;

  function automatic logic [PAR_W-1:0] vword(input logic [63:0] pay);
    return {1'b1, 15'd0, pay};
  endfunction

  task automatic gen(input int l, input bit corrupt);
    logic [63:0] pay;
    if (t_pos[l] == 0) pay = corrupt ? ~SYNC : SYNC;
    else begin
      pay = {8'(l), 24'h0, 32'(t_cnt[l])};
      t_cnt[l]++;
    end
    lw[l]     = vword(pay);
    t_last[l] = pay;
    t_pos[l]  = (t_pos[l] + 1) % PERIOD;
  endtask

  // Applies the lane words, clocks once, then leaves every lane idle (invalid word
  // carrying the sync pattern, which must be ignored).
  task automatic step();
    for (int l = 0; l < LANES; l++) din[l*PAR_W +: PAR_W] = lw[l];
    @(posedge clk);
    #1;
    for (int l = 0; l < LANES; l++) lw[l] = {1'b0, 15'd0, SYNC};
  endtask

  task automatic reset_model();
    for (int l = 0; l < LANES; l++) begin
      t_pos[l] = 0;
      t_cnt[l] = 0;
      lw[l]    = {1'b0, 15'd0, SYNC};
    end
  endtask

  task automatic test_reset();
    reset_model();
    rst_n = 1'b0; err_clear = 1'b0; s_clr = 1'b0; s_din = '0;
    step();
    step();
    n_checks++; if (rx_data !== '0) begin n_fail++; $display("FAIL reset_rx_data: got %0h expected 0", rx_data); end
    n_checks++; if (rx_valid !== '0) begin n_fail++; $display("FAIL reset_rx_valid: got %0b expected 0", rx_valid); end
    n_checks++; if (lane_locked !== '0) begin n_fail++; $display("FAIL reset_locked: got %0b expected 0", lane_locked); end
    n_checks++; if (all_locked !== 1'b0) begin n_fail++; $display("FAIL reset_all_locked: got %0b expected 0", all_locked); end
    n_checks++; if (err_count !== '0) begin n_fail++; $display("FAIL reset_err: got %0h expected 0", err_count); end
    n_checks++; if (s_locked !== 1'b0) begin n_fail++; $display("FAIL reset_sat_locked: got %0b expected 0", s_locked); end
    rst_n = 1'b1;
  endtask

  task automatic test_lock_lane0();
    for (int j = 0; j < 5*PERIOD; j++) begin
      logic el, ev;
      logic [63:0] pay;
      gen(0, 1'b0);
      pay = t_last[0];
      step();
      el = (j >= 48);
      ev = (j >= 49) && (j % PERIOD != 0);
      n_checks++; if (lane_locked[0] !== el) begin n_fail++; $display("FAIL lock0_locked j=%0d: got %0b expected %0b", j, lane_locked[0], el); end
      n_checks++; if (rx_valid[0] !== ev) begin n_fail++; $display("FAIL lock0_valid j=%0d: got %0b expected %0b", j, rx_valid[0], ev); end
      n_checks++; if (rx_data[63:0] !== pay) begin n_fail++; $display("FAIL lock0_data j=%0d: got %0h expected %0h", j, rx_data[63:0], pay); end
    end
    n_checks++; if (err_count[15:0] !== 16'd0) begin n_fail++; $display("FAIL lock0_err: got %0d expected 0", err_count[15:0]); end
    n_checks++; if (all_locked !== 1'b0) begin n_fail++; $display("FAIL lock0_all: got %0b expected 0", all_locked); end
  endtask

  task automatic test_all_locked();
    for (int c = 0; c < 5*PERIOD; c++) begin
      logic [3:0] el;
      gen(0, 1'b0);
      gen(1, 1'b0);
      if (c >= 5)  gen(2, 1'b0);
      if (c >= 10) gen(3, 1'b0);
      step();
      el = {c >= 58, c >= 53, c >= 48, 1'b1};
      n_checks++; if (lane_locked !== el) begin n_fail++; $display("FAIL stagger_locked c=%0d: got %0b expected %0b", c, lane_locked, el); end
      n_checks++; if (all_locked !== (c >= 58)) begin n_fail++; $display("FAIL stagger_all c=%0d: got %0b expected %0b", c, all_locked, c >= 58); end
    end
    n_checks++; if (rx_data[3*64 +: 64] !== t_last[3]) begin n_fail++; $display("FAIL stagger_data3: got %0h expected %0h", rx_data[3*64 +: 64], t_last[3]); end
  endtask

  task automatic test_gaps();
    for (int j = 0; j < PERIOD + 3 + PERIOD; j++) begin
      logic ev;
      if (j >= 6 && j <= 8) begin
        step();
        n_checks++; if (rx_valid[0] !== 1'b0) begin n_fail++; $display("FAIL gap_valid j=%0d: got %0b expected 0", j, rx_valid[0]); end
        n_checks++; if (rx_data[63:0] !== t_last[0]) begin n_fail++; $display("FAIL gap_hold j=%0d: got %0h expected %0h", j, rx_data[63:0], t_last[0]); end
      end else begin
        ev = (t_pos[0] != 0);
        gen(0, 1'b0);
        step();
        n_checks++; if (rx_valid[0] !== ev) begin n_fail++; $display("FAIL gap_slot_valid j=%0d: got %0b expected %0b", j, rx_valid[0], ev); end
      end
      n_checks++; if (lane_locked[0] !== 1'b1) begin n_fail++; $display("FAIL gap_locked j=%0d: got %0b expected 1", j, lane_locked[0]); end
    end
    n_checks++; if (err_count[15:0] !== 16'd0) begin n_fail++; $display("FAIL gap_err: got %0d expected 0", err_count[15:0]); end
    n_checks++; if (all_locked !== 1'b1) begin n_fail++; $display("FAIL gap_all: got %0b expected 1", all_locked); end
  endtask

  task automatic test_marker_errors();
    for (int p = 0; p < 7; p++) begin
      for (int s = 0; s < PERIOD; s++) begin
        gen(0, 1'b1);
        step();
        n_checks++; if (lane_locked[0] !== 1'b1) begin n_fail++; $display("FAIL miss7_locked p=%0d s=%0d: got %0b expected 1", p, s, lane_locked[0]); end
        n_checks++; if (rx_valid[0] !== (s != 0)) begin n_fail++; $display("FAIL miss7_valid p=%0d s=%0d: got %0b expected %0b", p, s, rx_valid[0], s != 0); end
      end
    end
    n_checks++; if (err_count[15:0] !== 16'd7) begin n_fail++; $display("FAIL miss7_err: got %0d expected 7", err_count[15:0]); end
    for (int s = 0; s < PERIOD; s++) begin
      gen(0, 1'b0);
      step();
    end
    n_checks++; if (lane_locked[0] !== 1'b1) begin n_fail++; $display("FAIL restore_locked: got %0b expected 1", lane_locked[0]); end
    for (int s = 0; s < PERIOD; s++) begin
      err_clear = (s == 0);
      gen(0, 1'b0);
      step();
      err_clear = 1'b0;
      if (s == 0) begin
        n_checks++; if (err_count[15:0] !== 16'd0) begin n_fail++; $display("FAIL clear_err: got %0d expected 0", err_count[15:0]); end
      end
    end
    for (int p = 0; p < 8; p++) begin
      for (int s = 0; s < PERIOD; s++) begin
        gen(0, 1'b1);
        step();
        n_checks++; if (lane_locked[0] !== (p < 7)) begin n_fail++; $display("FAIL miss8_locked p=%0d s=%0d: got %0b expected %0b", p, s, lane_locked[0], p < 7); end
        n_checks++; if (all_locked !== (p < 7)) begin n_fail++; $display("FAIL miss8_all p=%0d s=%0d: got %0b expected %0b", p, s, all_locked, p < 7); end
        n_checks++; if (rx_valid[0] !== (p < 7 && s != 0)) begin n_fail++; $display("FAIL miss8_valid p=%0d s=%0d: got %0b expected %0b", p, s, rx_valid[0], p < 7 && s != 0); end
      end
    end
    n_checks++; if (err_count[15:0] !== 16'd8) begin n_fail++; $display("FAIL miss8_err: got %0d expected 8", err_count[15:0]); end
    for (int p = 0; p < 4; p++) begin
      for (int s = 0; s < PERIOD; s++) begin
        gen(0, 1'b0);
        step();
        n_checks++; if (lane_locked[0] !== (p == 3)) begin n_fail++; $display("FAIL relock_locked p=%0d s=%0d: got %0b expected %0b", p, s, lane_locked[0], p == 3); end
        n_checks++; if (rx_valid[0] !== (p == 3 && s != 0)) begin n_fail++; $display("FAIL relock_valid p=%0d s=%0d: got %0b expected %0b", p, s, rx_valid[0], p == 3 && s != 0); end
      end
    end
    n_checks++; if (err_count[15:0] !== 16'd8) begin n_fail++; $display("FAIL relock_err: got %0d expected 8", err_count[15:0]); end
  endtask

  task automatic test_verify_fail();
    rst_n = 1'b0;
    reset_model();
    step();
    rst_n = 1'b1;
    for (int p = 0; p < 7; p++) begin
      for (int s = 0; s < PERIOD; s++) begin
        gen(0, p == 2);
        step();
        n_checks++; if (lane_locked[0] !== (p == 6)) begin n_fail++; $display("FAIL verify_locked p=%0d s=%0d: got %0b expected %0b", p, s, lane_locked[0], p == 6); end
        n_checks++; if (rx_valid[0] !== (p == 6 && s != 0)) begin n_fail++; $display("FAIL verify_valid p=%0d s=%0d: got %0b expected %0b", p, s, rx_valid[0], p == 6 && s != 0); end
      end
    end
    n_checks++; if (err_count[15:0] !== 16'd0) begin n_fail++; $display("FAIL verify_err: got %0d expected 0", err_count[15:0]); end
  endtask

  task automatic test_reset_midstream();
    for (int s = 0; s < 3; s++) begin
      gen(0, 1'b0);
      step();
    end
    n_checks++; if (rx_valid[0] !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid: got %0b expected 1", rx_valid[0]); end
    rst_n = 1'b0;
    #2;
    n_checks++; if (rx_valid !== '0) begin n_fail++; $display("FAIL mid_valid: got %0b expected 0", rx_valid); end
    n_checks++; if (lane_locked !== '0) begin n_fail++; $display("FAIL mid_locked: got %0b expected 0", lane_locked); end
    n_checks++; if (rx_data !== '0) begin n_fail++; $display("FAIL mid_data: got %0h expected 0", rx_data); end
    n_checks++; if (all_locked !== 1'b0) begin n_fail++; $display("FAIL mid_all: got %0b expected 0", all_locked); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
    for (int s = 0; s < PERIOD + 1; s++) begin
      gen(0, 1'b0);
      step();
    end
    n_checks++; if (lane_locked[0] !== 1'b0) begin n_fail++; $display("FAIL mid_relock: got %0b expected 0", lane_locked[0]); end
  endtask

  task automatic test_saturation();
    s_din = vword(SYNC);
    step();
    n_checks++; if (s_locked !== 1'b1) begin n_fail++; $display("FAIL sat_lock1: got %0b expected 1", s_locked); end
    for (int i = 0; i < 15; i++) begin
      s_din = vword(64'd0); step();
      s_din = vword(64'd0); step();
    end
    n_checks++; if (s_err !== 4'hF) begin n_fail++; $display("FAIL sat_reach: got %0h expected f", s_err); end
    s_din = vword(64'd0); step();
    s_din = vword(64'd0); step();
    n_checks++; if (s_err !== 4'hF) begin n_fail++; $display("FAIL sat_hold: got %0h expected f", s_err); end
    n_checks++; if (s_locked !== 1'b1) begin n_fail++; $display("FAIL sat_locked: got %0b expected 1", s_locked); end
    s_din = vword(64'd0); step();
    s_clr = 1'b1;
    s_din = vword(64'd0); step();
    s_clr = 1'b0;
    n_checks++; if (s_err !== 4'h0) begin n_fail++; $display("FAIL sat_clear: got %0h expected 0", s_err); end
    s_din = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    din = '0;
    test_reset();
    test_lock_lane0();
    test_all_locked();
    test_gaps();
    test_marker_errors();
    test_verify_fail();
    test_reset_midstream();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
